ysyx_25030093_lsu: RTL
======================

YSYX_25030093_LSU -- requirements
Module: ysyx_25030093_lsu

Interface
REQ-001 SHALL: clock  input  1  single clock, all state on rising edge.
REQ-002 SHALL: reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-003 SHALL: in_valid  input  1  upstream execute stage holds a valid result.
REQ-004 SHALL: in_ready  output  1  LSU can accept a new operation.
REQ-005 SHALL: lsu_op  input  4  operation: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW (encodings in package).
REQ-006 SHALL: ex_data  input  32  execute result; memory address for loads and stores, passthrough value for NONE.
REQ-007 SHALL: st_data  input  32  store source register value.
REQ-008 SHALL: out_valid  output  1  wb_data is valid for the writeback stage.
REQ-009 SHALL: out_ready  input  1  writeback stage accepts the result.
REQ-010 SHALL: wb_data  output  32  load result, ex_data for NONE, 0 for stores.
REQ-011 SHALL: out_err  output  1  misaligned-access flag, qualified by out_valid.
REQ-012 SHALL: mem_req_valid / mem_req_ready  output/input  1/1  memory request handshake.
REQ-013 SHALL: mem_wen  output  1;  mem_addr  output  32;  mem_wdata  output  32;  mem_wmask  output  4.
REQ-014 SHALL: mem_resp_valid  input  1;  mem_rdata  input  32.  The LSU accepts a response whenever it is in WAIT.

Function
REQ-015 SHALL: states IDLE, REQ, WAIT, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL: on in_valid&in_ready, latch lsu_op, ex_data and st_data into internal registers; all later behaviour uses the latched copies.
REQ-017 SHALL: IDLE->REQ on accept of a load or store; IDLE->DONE on accept of NONE (out_valid in the next cycle).
REQ-018 SHALL: in REQ, hold mem_req_valid=1 with constant addr, wdata, wmask and wen until mem_req_ready=1, then go to WAIT.
REQ-019 SHALL: in WAIT, go to DONE on mem_resp_valid; for a load, capture the extended mem_rdata into wb_data in that same cycle.
REQ-020 SHALL: in DONE, hold out_valid and wb_data stable until out_ready=1, then go to IDLE.
REQ-021 SHALL: the minimum load/store latency is 3 cycles from accept to out_valid, with zero-wait memory.
REQ-022 SHALL: mem_addr = {addr[31:2],2'b00}.
REQ-023 SHALL: wmask = SB 0001<<addr[1:0], SH 0011<<{addr[1],1'b0}, SW 1111, loads 0000.
REQ-024 SHALL: store data is replicated into the byte lanes.
REQ-025 SHALL: loads select the addressed lane; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-026 SHALL: mem_resp_valid outside WAIT is ignored.
REQ-027 SHALL: in_valid is ignored while not IDLE.
REQ-028 SHALL: an unused lsu_op encoding behaves as NONE.

Reset
REQ-029 SHALL: reset=0 at a clock edge forces IDLE, out_valid=0, mem_req_valid=0, wb_data=0, out_err=0 and latched registers=0.
REQ-030 SHALL: reset asserted mid-transaction (REQ, WAIT or DONE) abandons the transaction; any later response is dropped per REQ-026.

Configuration
REQ-031 SHALL: with YSYX_25030093_LSU_MISALIGN_CHK_EN defined, an LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]!=0, goes IDLE->DONE with no memory request, out_err=1 and wb_data=0.
REQ-032 SHALL: without YSYX_25030093_LSU_MISALIGN_CHK_EN, out_err is tied 0 and misaligned addresses are truncated to the access size (half: addr[0] forced 0; word: addr[1:0] forced 0).

Structure
REQ-033 SHALL: package ysyx_25030093_pkg holds the lsu_op encodings, the LSU state encoding and the mask constants.
REQ-034 SHALL: combinational sub-module ysyx_25030093_lsu_align computes wmask, lane-replicated wdata and load extension; the FSM lives in ysyx_25030093_lsu.

Verification
REQ-035 SHALL: LW addr 0x80000004 with mem_rdata 0xDEADBEEF and zero-wait memory -> mem_addr 0x80000004, out_valid 3 cycles after accept, wb_data 0xDEADBEEF.
REQ-036 SHALL: LB addr 0x80000003 with rdata 0x80FF1234 -> wb_data 0xFFFFFF80; LBU at the same addr -> 0x00000080.
REQ-037 SHALL: SH addr 0x80000002 with st_data 0x0000ABCD -> mem_wen=1, wmask 1100, mem_wdata 0xABCDABCD, wb_data 0.
REQ-038 SHALL: mem_req_ready held low 4 cycles and out_ready held low 2 cycles -> request fields stable throughout, out_valid held, in_ready=0 until release.
REQ-039 SHALL: NONE with ex_data 0x12345678 -> out_valid next cycle, wb_data 0x12345678, no mem_req_valid.
REQ-040 SHALL: reset=0 during WAIT, then a late mem_resp_valid -> IDLE, response ignored; with the macro defined, LW addr 0x80000001 -> out_err=1 and no request.

Source files
------------

// File: rtl/ysyx_25030093_lsu_pkg.sv
// rtl/ysyx_25030093_lsu_pkg.sv - LSU operation, state and byte-mask encodings
package ysyx_25030093_pkg;

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LBU  = 4'd4,
        LSU_LHU  = 4'd5,
        LSU_SB   = 4'd6,
        LSU_SH   = 4'd7,
        LSU_SW   = 4'd8
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [3:0] MASK_NONE = 4'b0000;
    localparam logic [3:0] MASK_B    = 4'b0001;
    localparam logic [3:0] MASK_H    = 4'b0011;
    localparam logic [3:0] MASK_W    = 4'b1111;

    function automatic logic is_load(input logic [3:0] op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        case (op)
            LSU_LH, LSU_LHU, LSU_SH: return lo[0];
            LSU_LW, LSU_SW:          return |lo;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_if.sv
// rtl/ysyx_25030093_lsu_if.sv - LSU memory request/response bus
interface ysyx_25030093_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata
    );

    modport slave (
        input  mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata
    );
endinterface

// File: rtl/ysyx_25030093_lsu_align.sv
// rtl/ysyx_25030093_lsu_align.sv - byte-lane mask, store replication and load extension
module ysyx_25030093_lsu_align
    import ysyx_25030093_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    logic [1:0]  off;
    logic [31:0] lane;

    always_comb begin
        off       = 2'b00;
        wmask     = MASK_NONE;
        wdata     = 32'd0;
        load_data = 32'd0;
        // Half and word offsets drop the low address bits, truncating misaligned accesses.
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: off = addr_lo;
            LSU_LH, LSU_LHU, LSU_SH: off = {addr_lo[1], 1'b0};
            default:                 off = 2'b00;
        endcase
        lane = rdata >> {off, 3'b000};
        case (op)
            LSU_LB:  load_data = {{24{lane[7]}}, lane[7:0]};
            LSU_LBU: load_data = {24'd0, lane[7:0]};
            LSU_LH:  load_data = {{16{lane[15]}}, lane[15:0]};
            LSU_LHU: load_data = {16'd0, lane[15:0]};
            LSU_LW:  load_data = rdata;
            LSU_SB: begin
                wmask = MASK_B << off;
                wdata = {4{st_data[7:0]}};
            end
            LSU_SH: begin
                wmask = MASK_H << off;
                wdata = {2{st_data[15:0]}};
            end
            LSU_SW: begin
                wmask = MASK_W;
                wdata = st_data;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/ysyx_25030093_lsu.sv
// rtl/ysyx_25030093_lsu.sv - LSU FSM; misaligned trap under YSYX_25030093_LSU_MISALIGN_CHK_EN
module ysyx_25030093_lsu
    import ysyx_25030093_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 lsu_op,
    input  logic [31:0]                ex_data,
    input  logic [31:0]                st_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                wb_data,
    output logic                       out_err,
    ysyx_25030093_lsu_if.master        mem
);
    lsu_state_e  state, state_nxt;
    logic [3:0]  op_q;
    logic [31:0] addr_q, st_q, wb_q;
    logic [3:0]  wmask;
    logic [31:0] wdata, load_data;
    logic        accept, bad_in;

    assign accept = in_valid && (state == ST_IDLE);

`ifdef YSYX_25030093_LSU_MISALIGN_CHK_EN
    logic err_q;
    assign bad_in  = is_misaligned(lsu_op, ex_data[1:0]);
    assign out_err = err_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= bad_in;
        end
    end
`else
    assign bad_in  = 1'b0;
    assign out_err = 1'b0;
`endif

    ysyx_25030093_lsu_align u_align (
        .op        (op_q),
        .addr_lo   (addr_q[1:0]),
        .st_data   (st_q),
        .rdata     (mem.mem_rdata),
        .wmask     (wmask),
        .wdata     (wdata),
        .load_data (load_data)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= ST_IDLE;
            op_q   <= 4'd0;
            addr_q <= 32'd0;
            st_q   <= 32'd0;
            wb_q   <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q   <= lsu_op;
                addr_q <= ex_data;
                st_q   <= st_data;
                // Stores and trapped accesses write back 0; NONE and unused opcodes pass ex_data.
                wb_q   <= (is_load(lsu_op) || is_store(lsu_op) || bad_in) ? 32'd0 : ex_data;
            end else if (state == ST_WAIT && mem.mem_resp_valid && is_load(op_q)) begin
                wb_q <= load_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)
                         state_nxt = ((is_load(lsu_op) || is_store(lsu_op)) && !bad_in)
                                     ? ST_REQ : ST_DONE;
            ST_REQ:  if (mem.mem_req_ready)  state_nxt = ST_WAIT;
            ST_WAIT: if (mem.mem_resp_valid) state_nxt = ST_DONE;
            ST_DONE: if (out_ready)          state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign in_ready          = (state == ST_IDLE);
    assign out_valid         = (state == ST_DONE);
    assign wb_data           = wb_q;
    assign mem.mem_req_valid = (state == ST_REQ);
    assign mem.mem_wen       = is_store(op_q);
    assign mem.mem_addr      = {addr_q[31:2], 2'b00};
    assign mem.mem_wmask     = wmask;
    assign mem.mem_wdata     = wdata;
endmodule
